// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding,
// default FIFO depth, error-counter width and a saturating increment helper.
package uart_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W     = 8;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Increment that holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1'b1);
        end
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and host-side handshake bundle of the UART receive controller.
// The controller sits on the slave modport; the receiver/host model on master.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_err_frame;
    logic          rx_enable;
    logic          rx_not_ready;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_empty;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  rx_data, rx_valid, rx_err_frame, rd_en,
        output rx_enable, rx_not_ready, rd_data, rd_empty, fifo_count
    );

    modport master (
        output rx_data, rx_valid, rx_err_frame, rd_en,
        input  rx_enable, rx_not_ready, rd_data, rd_empty, fifo_count
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through read. A push into a full FIFO is
// only taken when a pop retires the head in the same cycle; pops on an
// empty FIFO are ignored, so the occupancy can neither overflow nor underflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     sample_clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          rd_ok_s;
    logic          wr_ok_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign rd_ok_s = pop && (count_r != CW'(1'b0));
    assign wr_ok_s = push && (!full_s || rd_ok_s);

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge sample_clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

    // Occupancy tracks net push/pop; simultaneous push and pop leave it unchanged.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == CW'(1'b0));
    assign count = count_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: run/stall/drain FSM with hysteresis back-pressure,
// overrun and frame-error accounting, and a FWFT byte FIFO toward the host.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int RESUME_LVL = 2
) (
    input  logic              sample_clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  err_frame_cnt,
    output logic [CNT_W-1:0]  err_ovr_cnt,
    output logic [1:0]        state,
    uart_rx_ctrl_if.slave     bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] RESUME_CNT = CW'(RESUME_LVL);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             rx_enable_r;
    logic             rx_not_ready_r;
    logic [CNT_W-1:0] err_frame_r;
    logic [CNT_W-1:0] err_ovr_r;
    logic             active_s;
    logic             full_s;
    logic             push_req_s;
    logic             ovr_s;
    logic             ferr_s;
    logic             push_s;

    // Receive-side decisions: only RUN/STALL listen; a full FIFO drops unless popped.
    always_comb begin
        active_s   = (state_r == ST_RUN) || (state_r == ST_STALL);
        full_s     = (bus.fifo_count == FULL_LVL);
        push_req_s = active_s && bus.rx_valid && !bus.rx_err_frame;
        ovr_s      = push_req_s && full_s && !bus.rd_en;
        ferr_s     = active_s && bus.rx_valid && bus.rx_err_frame;
        push_s     = push_req_s && !ovr_s;
    end

    // Next-state logic; disable always wins, DRAIN ignores enable until empty.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_OFF;
            end
            ST_RUN: begin
                if (!enable)     state_nxt_s = ST_DRAIN;
                else if (full_s) state_nxt_s = ST_STALL;
                else             state_nxt_s = ST_RUN;
            end
            ST_STALL: begin
                if (!enable)                           state_nxt_s = ST_DRAIN;
                else if (bus.fifo_count <= RESUME_CNT) state_nxt_s = ST_RUN;
                else                                   state_nxt_s = ST_STALL;
            end
            ST_DRAIN: begin
                if (bus.rd_empty) state_nxt_s = ST_OFF;
                else              state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // State register and its registered decodes toward the receiver.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= ST_OFF;
            rx_enable_r    <= 1'b0;
            rx_not_ready_r <= 1'b1;
        end else begin
            state_r        <= state_nxt_s;
            rx_enable_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STALL);
            rx_not_ready_r <= (state_nxt_s != ST_RUN);
        end
    end

    // Saturating error counters; a clear overrides a same-cycle increment.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            err_frame_r <= '0;
            err_ovr_r   <= '0;
        end else if (clr_err) begin
            err_frame_r <= '0;
            err_ovr_r   <= '0;
        end else begin
            if (ferr_s) begin
                err_frame_r <= sat_inc(err_frame_r);
            end
            if (ovr_s) begin
                err_ovr_r <= sat_inc(err_ovr_r);
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sample_clk (sample_clk),
        .rstn       (rstn),
        .push       (push_s),
        .din        (bus.rx_data),
        .pop        (bus.rd_en),
        .dout       (bus.rd_data),
        .empty      (bus.rd_empty),
        .count      (bus.fifo_count)
    );

    assign state            = state_r;
    assign bus.rx_enable    = rx_enable_r;
    assign bus.rx_not_ready = rx_not_ready_r;
    assign err_frame_cnt    = err_frame_r;
    assign err_ovr_cnt      = err_ovr_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=4, RESUME_LVL=2) with hand-computed
// expectations. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, so registered results of the edge are visible.
module tb_uart_rx_ctrl;

    logic       sample_clk;
    logic       rstn;
    logic       enable;
    logic       clr_err;
    logic [7:0] err_frame_cnt;
    logic [7:0] err_ovr_cnt;
    logic [1:0] state;

    int n_pass;
    int n_total;

    uart_rx_ctrl_if #(.DEPTH(4)) bus ();

    uart_rx_ctrl #(
        .DEPTH      (4),
        .RESUME_LVL (2)
    ) dut (
        .sample_clk    (sample_clk),
        .rstn          (rstn),
        .enable        (enable),
        .clr_err       (clr_err),
        .err_frame_cnt (err_frame_cnt),
        .err_ovr_cnt   (err_ovr_cnt),
        .state         (state),
        .bus           (bus)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rstn             = 1'b0;
        enable           = 1'b0;
        clr_err          = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.rx_err_frame = 1'b0;
        bus.rd_en        = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_state",   32'(state),            32'd0);
        check("rst_rx_en",   32'(bus.rx_enable),    32'd0);
        check("rst_nrdy",    32'(bus.rx_not_ready), 32'd1);
        check("rst_count",   32'(bus.fifo_count),   32'd0);
        check("rst_empty",   32'(bus.rd_empty),     32'd1);
        check("rst_ferr",    32'(err_frame_cnt),    32'd0);
        check("rst_ovr",     32'(err_ovr_cnt),      32'd0);
        rstn = 1'b1;
        tick();
        check("off_hold",    32'(state),            32'd0);

        // Basic push/pop with FWFT head
        enable = 1'b1;
        tick();
        check("run_state",   32'(state),            32'd1);
        check("run_rx_en",   32'(bus.rx_enable),    32'd1);
        check("run_nrdy",    32'(bus.rx_not_ready), 32'd0);
        push(8'h55);
        check("p1_data",     32'(bus.rd_data),      32'h55);
        check("p1_count",    32'(bus.fifo_count),   32'd1);
        push(8'hAA);
        check("p2_data",     32'(bus.rd_data),      32'h55);
        check("p2_count",    32'(bus.fifo_count),   32'd2);
        pop();
        check("pop1_data",   32'(bus.rd_data),      32'hAA);
        check("pop1_count",  32'(bus.fifo_count),   32'd1);
        pop();
        check("pop2_empty",  32'(bus.rd_empty),     32'd1);
        pop();
        check("under_count", 32'(bus.fifo_count),   32'd0);
        check("under_empty", 32'(bus.rd_empty),     32'd1);

        // Fill, stall, overrun, hysteresis release
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
        end
        check("full_count",  32'(bus.fifo_count),   32'd4);
        check("full_run",    32'(state),            32'd1);
        push(8'h05);
        check("ovr_state",   32'(state),            32'd2);
        check("ovr_nrdy",    32'(bus.rx_not_ready), 32'd1);
        check("ovr_rx_en",   32'(bus.rx_enable),    32'd1);
        check("ovr_cnt",     32'(err_ovr_cnt),      32'd1);
        check("ovr_count",   32'(bus.fifo_count),   32'd4);
        check("ovr_head",    32'(bus.rd_data),      32'h01);
        pop();
        check("st_pop1",     32'(state),            32'd2);
        check("st_pop1_d",   32'(bus.rd_data),      32'h02);
        pop();
        check("st_pop2",     32'(state),            32'd2);
        check("st_pop2_c",   32'(bus.fifo_count),   32'd2);
        tick();
        check("resume_st",   32'(state),            32'd1);
        check("resume_nrdy", 32'(bus.rx_not_ready), 32'd0);

        // Full FIFO with simultaneous push and pop (pointers wrap here)
        push(8'h06);
        push(8'h07);
        check("refill_cnt",  32'(bus.fifo_count),   32'd4);
        bus.rx_data  = 8'h08;
        bus.rx_valid = 1'b1;
        bus.rd_en    = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rd_en    = 1'b0;
        check("pp_count",    32'(bus.fifo_count),   32'd4);
        check("pp_ovr",      32'(err_ovr_cnt),      32'd1);
        check("pp_head",     32'(bus.rd_data),      32'h04);
        pop();
        check("pp_d1",       32'(bus.rd_data),      32'h06);
        pop();
        check("pp_d2",       32'(bus.rd_data),      32'h07);
        pop();
        check("pp_tail",     32'(bus.rd_data),      32'h08);
        check("pp_state",    32'(state),            32'd1);
        pop();
        check("pp_empty",    32'(bus.rd_empty),     32'd1);

        // Frame errors saturate and leave the FIFO alone
        push(8'h99);
        bus.rx_valid     = 1'b1;
        bus.rx_err_frame = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check("ferr_sat",    32'(err_frame_cnt),    32'd255);
        check("ferr_count",  32'(bus.fifo_count),   32'd1);
        check("ferr_head",   32'(bus.rd_data),      32'h99);
        check("ferr_ovr",    32'(err_ovr_cnt),      32'd1);
        clr_err = 1'b1;
        tick();
        clr_err          = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_err_frame = 1'b0;
        check("clr_ferr",    32'(err_frame_cnt),    32'd0);
        check("clr_ovr",     32'(err_ovr_cnt),      32'd0);

        // Drain: ignore receive traffic and enable until empty
        push(8'h11);
        push(8'h22);
        check("dr_count",    32'(bus.fifo_count),   32'd3);
        enable = 1'b0;
        tick();
        check("dr_state",    32'(state),            32'd3);
        check("dr_rx_en",    32'(bus.rx_enable),    32'd0);
        check("dr_nrdy",     32'(bus.rx_not_ready), 32'd1);
        enable = 1'b1;
        push(8'h33);
        bus.rx_err_frame = 1'b1;
        push(8'h44);
        bus.rx_err_frame = 1'b0;
        enable = 1'b0;
        check("dr_ignore_c", 32'(bus.fifo_count),   32'd3);
        check("dr_ignore_e", 32'(err_frame_cnt),    32'd0);
        check("dr_hold",     32'(state),            32'd3);
        pop();
        check("dr_d1",       32'(bus.rd_data),      32'h11);
        pop();
        check("dr_d2",       32'(bus.rd_data),      32'h22);
        pop();
        check("dr_empty",    32'(bus.rd_empty),     32'd1);
        tick();
        check("dr_off",      32'(state),            32'd0);
        check("dr_off_nrdy", 32'(bus.rx_not_ready), 32'd1);

        // Asynchronous reset in the middle of STALL
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            push(8'hC0 + 8'(i));
        end
        push(8'hCF);
        check("ar_stall",    32'(state),            32'd2);
        check("ar_ovr_pre",  32'(err_ovr_cnt),      32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_state",    32'(state),            32'd0);
        check("ar_count",    32'(bus.fifo_count),   32'd0);
        check("ar_nrdy",     32'(bus.rx_not_ready), 32'd1);
        check("ar_rx_en",    32'(bus.rx_enable),    32'd0);
        check("ar_empty",    32'(bus.rd_empty),     32'd1);
        check("ar_ovr",      32'(err_ovr_cnt),      32'd0);
        enable = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("ar_post",     32'(state),            32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
